pc_vector_sequencer: RTL
========================

Name: pc_vector_sequencer

Overview:
- Control FSM that sequences the PC unit through reset-vector and interrupt-vector loads. It owns the data-memory port while a vector fetch or return-address push is in progress.
- Reset path: fetches M[VEC_RST] and pulses the PC reset-load.
- Interrupt path: stalls fetch, drains the pipeline, pushes the return PC to the stack, fetches M[VEC_INT], then pulses the PC interrupt-load.
- Sits between the top-level control, the data memory mux, the stack pointer and the PC unit.

Parameters:
- VEC_RST, 8'h00, memory address of the reset vector
- VEC_INT, 8'h01, memory address of the interrupt vector
- RD_LAT, 1, cycles from mem_rd to valid vector data at the PC unit (1..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rst_req  in  1  project reset request (level, synchronous)
- intr_req  in  1  external interrupt (level; rising edge latched)
- pipe_empty  in  1  high when no instruction is in flight past fetch
- rti_done  in  1  one-cycle pulse when a return-from-interrupt retires
- pc_cur  in  8  current PC (return address to push)
- sp_in  in  8  current stack pointer
- mem_sel  out  1  1 = sequencer drives the data-memory port
- mem_addr  out  8  memory address while mem_sel = 1
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  8  write data
- sp_dec  out  1  one-cycle SP decrement after push
- pc_rst_load  out  1  drives the PC unit reset-load input
- pc_intr_load  out  1  drives the PC unit interrupt-load input
- fetch_stall  out  1  freeze fetch/PC increment
- flush  out  1  invalidate pipeline registers
- in_isr  out  1  interrupt service in progress
- busy  out  1  FSM not in IDLE

Behaviour:
- rst_n low: all outputs 0, pending = 0, state = BOOT.
- First clk after rst_n rises: BOOT moves to RST_RD, so the boot vector is always fetched.
- States: IDLE, RST_RD, RST_WAIT, RST_LD, INT_DRAIN, INT_PUSH, INT_RD, INT_WAIT, INT_LD.
- RST_RD:
  - Drives mem_sel = 1, mem_addr = VEC_RST, mem_rd = 1, fetch_stall = 1, flush = 1.
  - If RD_LAT = 1, goes directly to RST_LD; otherwise RST_WAIT holds for RD_LAT-1 cycles (2-bit counter).
- RST_LD:
  - Holds mem_addr = VEC_RST, pc_rst_load = 1 for exactly one cycle.
  - Clears in_isr and pending, then returns to IDLE.
- rst_req high in any state: next state is RST_RD, with the counter, pending and in_isr cleared.
  - No mem_wr or sp_dec is issued after that edge.
  - While rst_req stays high, the FSM stays in RST_RD.
  - The sequence completes after rst_req falls.
- Interrupt latching:
  - A rising edge of intr_req (registered previous value) sets pending.
  - Edges while pending = 1 are absorbed (not counted).
- IDLE with pending = 1, in_isr = 0, rst_req = 0: go to INT_DRAIN.
- INT_DRAIN: fetch_stall = 1; wait for pipe_empty = 1 with no timeout, then go to INT_PUSH.
- INT_PUSH, one cycle:
  - mem_sel = 1, mem_addr = sp_in, mem_wdata = pc_cur, mem_wr = 1, sp_dec = 1.
  - pc_cur is sampled in this cycle.
- INT_RD / INT_WAIT: same as the reset path, using VEC_INT.
- INT_LD: pc_intr_load = 1 for one cycle; in_isr is set and pending cleared on the same edge; then IDLE.
- rti_done clears in_isr.
  - A pending interrupt is serviced in the cycle after in_isr falls (nested interrupts are blocked).
- Simultaneous events:
  - rst_req and pending in IDLE: reset wins and pending is cleared.
  - rti_done and a new edge on the same cycle: both take effect.
- pc_rst_load and pc_intr_load are never high together. mem_rd and mem_wr are never high together.
- busy = (state != IDLE). mem_sel = 1 only in the RD, WAIT, LD and PUSH states.

Test Plan:
- Release rst_n with RD_LAT = 1 → mem_rd at addr 8'h00 on cycle 1, pc_rst_load on cycle 2, then IDLE; busy is high for exactly 2 cycles.
- IDLE, pc_cur = 8'h3A, sp_in = 8'hFF, pipe_empty held low 3 cycles then high → fetch_stall high throughout; one write of 8'h3A to 8'hFF with sp_dec = 1; mem_rd at 8'h01; pc_intr_load pulse; in_isr = 1.
- A second intr_req edge while in_isr = 1 → no service; pulse rti_done → INT_DRAIN entered on the next cycle and the push occurs.
- rst_req asserted during INT_DRAIN (before the push) → no mem_wr or sp_dec; RST_RD next cycle; pending = 0; in_isr = 0.
- RD_LAT = 3 → exactly 2 RST_WAIT cycles between mem_rd and pc_rst_load, with mem_addr held at 8'h00.
- rst_n pulled low during INT_PUSH → all outputs 0 immediately (asynchronously); BOOT sequence runs again after release.

Source files
------------

// File: rtl/pc_vector_sequencer.sv
// Control FSM that steers the PC unit through reset-vector and interrupt-vector loads,
// owning the data-memory port while a vector fetch or return-address push is in progress.
module pc_vector_sequencer #(
  parameter logic [7:0] VEC_RST = 8'h00,
  parameter logic [7:0] VEC_INT = 8'h01,
  parameter int         RD_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rst_req,
  input  logic       intr_req,
  input  logic       pipe_empty,
  input  logic       rti_done,
  input  logic [7:0] pc_cur,
  input  logic [7:0] sp_in,
  output logic       mem_sel,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic       sp_dec,
  output logic       pc_rst_load,
  output logic       pc_intr_load,
  output logic       fetch_stall,
  output logic       flush,
  output logic       in_isr,
  output logic       busy
);

  localparam logic [3:0] S_BOOT      = 4'd0;
  localparam logic [3:0] S_IDLE      = 4'd1;
  localparam logic [3:0] S_RST_RD    = 4'd2;
  localparam logic [3:0] S_RST_WAIT  = 4'd3;
  localparam logic [3:0] S_RST_LD    = 4'd4;
  localparam logic [3:0] S_INT_DRAIN = 4'd5;
  localparam logic [3:0] S_INT_PUSH  = 4'd6;
  localparam logic [3:0] S_INT_RD    = 4'd7;
  localparam logic [3:0] S_INT_WAIT  = 4'd8;
  localparam logic [3:0] S_INT_LD    = 4'd9;

  // Wait countdown start; only meaningful when RD_LAT > 1.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 2);

  logic [3:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       in_isr_q, in_isr_d;
  logic       intr_prev_q;
  logic       intr_edge;

  logic       mem_sel_q, mem_sel_d;
  logic [7:0] addr_q, addr_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic       sp_dec_q, sp_dec_d;
  logic       pc_rst_load_q, pc_rst_load_d;
  logic       pc_intr_load_q, pc_intr_load_d;
  logic       fetch_stall_q, fetch_stall_d;
  logic       flush_q, flush_d;
  logic       busy_q, busy_d;

  // Interrupt latch and in-service flag; a completed load sequence clears/sets them.
  always_comb begin
    intr_edge = intr_req & ~intr_prev_q;
    if (rst_req || state_q == S_RST_LD || state_q == S_INT_LD) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q | intr_edge;
    end
    if (rst_req || state_q == S_RST_LD) begin
      in_isr_d = 1'b0;
    end else if (state_q == S_INT_LD) begin
      in_isr_d = 1'b1;
    end else if (rti_done) begin
      in_isr_d = 1'b0;
    end else begin
      in_isr_d = in_isr_q;
    end
  end

  // Next-state logic; IDLE looks at the next in_isr so service starts right after rti_done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_req) begin
      state_d = S_RST_RD;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RST_RD;
        S_IDLE: begin
          if (pending_q && !in_isr_d) state_d = S_INT_DRAIN;
          else                        state_d = S_IDLE;
        end
        S_RST_RD, S_INT_RD: begin
          if (RD_LAT == 1) begin
            state_d = (state_q == S_RST_RD) ? S_RST_LD : S_INT_LD;
          end else begin
            state_d = (state_q == S_RST_RD) ? S_RST_WAIT : S_INT_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
        S_RST_WAIT, S_INT_WAIT: begin
          if (cnt_q == 2'd0) state_d = (state_q == S_RST_WAIT) ? S_RST_LD : S_INT_LD;
          else               cnt_d   = cnt_q - 2'd1;
        end
        S_RST_LD, S_INT_LD: state_d = S_IDLE;
        S_INT_DRAIN: begin
          if (pipe_empty) state_d = S_INT_PUSH;
          else            state_d = S_INT_DRAIN;
        end
        S_INT_PUSH: state_d = S_INT_RD;
        default:    state_d = S_RST_RD;
      endcase
    end
  end

  // Output decode from the next state so every strobe is a flop aligned with state_q.
  always_comb begin
    busy_d         = (state_d != S_IDLE) && (state_d != S_BOOT);
    fetch_stall_d  = busy_d;
    mem_rd_d       = (state_d == S_RST_RD) || (state_d == S_INT_RD);
    flush_d        = mem_rd_d;
    mem_wr_d       = (state_d == S_INT_PUSH);
    sp_dec_d       = (state_d == S_INT_PUSH);
    pc_rst_load_d  = (state_d == S_RST_LD);
    pc_intr_load_d = (state_d == S_INT_LD);
    case (state_d)
      S_RST_RD, S_RST_WAIT, S_RST_LD: begin
        mem_sel_d = 1'b1;
        addr_d    = VEC_RST;
      end
      S_INT_RD, S_INT_WAIT, S_INT_LD: begin
        mem_sel_d = 1'b1;
        addr_d    = VEC_INT;
      end
      S_INT_PUSH: begin
        mem_sel_d = 1'b1;
        addr_d    = 8'h00;
      end
      default: begin
        mem_sel_d = 1'b0;
        addr_d    = 8'h00;
      end
    endcase
  end

  // State, latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_BOOT;
      cnt_q          <= 2'd0;
      pending_q      <= 1'b0;
      in_isr_q       <= 1'b0;
      intr_prev_q    <= 1'b0;
      mem_sel_q      <= 1'b0;
      addr_q         <= 8'h00;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      sp_dec_q       <= 1'b0;
      pc_rst_load_q  <= 1'b0;
      pc_intr_load_q <= 1'b0;
      fetch_stall_q  <= 1'b0;
      flush_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      in_isr_q       <= in_isr_d;
      intr_prev_q    <= intr_req;
      mem_sel_q      <= mem_sel_d;
      addr_q         <= addr_d;
      mem_rd_q       <= mem_rd_d;
      mem_wr_q       <= mem_wr_d;
      sp_dec_q       <= sp_dec_d;
      pc_rst_load_q  <= pc_rst_load_d;
      pc_intr_load_q <= pc_intr_load_d;
      fetch_stall_q  <= fetch_stall_d;
      flush_q        <= flush_d;
      busy_q         <= busy_d;
    end
  end

  // The push cycle forwards the live stack pointer and return PC.
  assign mem_addr     = mem_wr_q ? sp_in  : addr_q;
  assign mem_wdata    = mem_wr_q ? pc_cur : 8'h00;
  assign mem_sel      = mem_sel_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign sp_dec       = sp_dec_q;
  assign pc_rst_load  = pc_rst_load_q;
  assign pc_intr_load = pc_intr_load_q;
  assign fetch_stall  = fetch_stall_q;
  assign flush        = flush_q;
  assign in_isr       = in_isr_q;
  assign busy         = busy_q;

endmodule
